// File: rtl/poly_mem_pkg.sv
// Shared defaults and FSM state type for the double-banked polynomial coefficient RAM.
package poly_mem_pkg;

  localparam int unsigned RAM_WIDTH_DEF     = 13;
  localparam int unsigned RAM_ADDR_BITS_DEF = 11;
  localparam int unsigned DEPTH_DEF         = 757;
  localparam int unsigned Q_DEF             = 4591;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } poly_mem_state_t;

endpackage

// File: rtl/dist_ram_bank.sv
// Single distributed-RAM bank: one synchronous write port, one asynchronous read port.
module dist_ram_bank #(
  parameter int unsigned RAM_WIDTH     = 13,
  parameter int unsigned RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [RAM_ADDR_BITS-1:0] waddr,
  input  logic [RAM_WIDTH-1:0]     wdata,
  input  logic [RAM_ADDR_BITS-1:0] raddr,
  output logic [RAM_WIDTH-1:0]     rdata
);

  logic [RAM_WIDTH-1:0] mem [2**RAM_ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/poly_bank_ram.sv
// Ping-pong coefficient RAM with zero-fill of the write bank.
// Define POLY_BANK_MODQ_EN to reduce written coefficients by one conditional subtraction of Q.
module poly_bank_ram
  import poly_mem_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = RAM_WIDTH_DEF,
  parameter int unsigned RAM_ADDR_BITS = RAM_ADDR_BITS_DEF,
  parameter int unsigned DEPTH         = DEPTH_DEF,
  parameter int unsigned Q             = Q_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_enable,
  input  logic [RAM_ADDR_BITS-1:0] write_address,
  input  logic [RAM_WIDTH-1:0]     input_data,
  input  logic                     read_enable,
  input  logic [RAM_ADDR_BITS-1:0] read_address,
  output logic [RAM_WIDTH-1:0]     output_data,
  output logic                     read_valid,
  input  logic                     swap,
  input  logic                     clear,
  output logic                     busy,
  output logic                     bank_sel
);

`ifdef POLY_BANK_MODQ_EN
  localparam bit MODQ_ON = 1'b1;
`else
  localparam bit MODQ_ON = 1'b0;
`endif

  localparam logic [RAM_ADDR_BITS:0]   DEPTH_W = (RAM_ADDR_BITS+1)'(DEPTH);
  localparam logic [RAM_ADDR_BITS-1:0] LAST    = RAM_ADDR_BITS'(DEPTH - 1);
  localparam logic [RAM_WIDTH-1:0]     Q_W     = RAM_WIDTH'(Q);

  poly_mem_state_t           state;
  logic [RAM_ADDR_BITS-1:0]  clr_cnt;
  logic [RAM_WIDTH-1:0]      stored;
  logic                      wr_en;
  logic [RAM_ADDR_BITS-1:0]  wr_addr;
  logic [RAM_WIDTH-1:0]      wr_data;
  logic [RAM_WIDTH-1:0]      rdata0;
  logic [RAM_WIDTH-1:0]      rdata1;
  logic [RAM_WIDTH-1:0]      rd_word;
  logic                      wr_addr_ok;
  logic                      rd_addr_ok;

  assign wr_addr_ok = {1'b0, write_address} < DEPTH_W;
  assign rd_addr_ok = {1'b0, read_address}  < DEPTH_W;
  assign rd_word    = bank_sel ? rdata1 : rdata0;

  always_comb begin
    stored = input_data;
    if (MODQ_ON && (input_data >= Q_W)) stored = input_data - Q_W;
  end

  // Zero-fill owns the write port while CLEAR; host writes are dropped, and rst blocks both.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = write_address;
    wr_data = stored;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
      end else begin
        wr_en = write_enable && wr_addr_ok;
      end
    end
  end

  dist_ram_bank #(.RAM_WIDTH(RAM_WIDTH), .RAM_ADDR_BITS(RAM_ADDR_BITS)) u_bank0 (
    .clk   (clk),
    .we    (wr_en && bank_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (read_address),
    .rdata (rdata0)
  );

  dist_ram_bank #(.RAM_WIDTH(RAM_WIDTH), .RAM_ADDR_BITS(RAM_ADDR_BITS)) u_bank1 (
    .clk   (clk),
    .we    (wr_en && !bank_sel),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (read_address),
    .rdata (rdata1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clr_cnt     <= '0;
      busy        <= 1'b0;
      bank_sel    <= 1'b0;
      output_data <= '0;
      read_valid  <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable) output_data <= rd_addr_ok ? rd_word : '0;
      if (swap && !busy) bank_sel <= ~bank_sel;
      case (state)
        IDLE: begin
          if (clear) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
